pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage LEGv8 pipeline. Produces per-stage register enables and flushes from load-use hazards in ID, branches resolved in MEM, and a variable-latency data-memory handshake. Holds a memory-wait watchdog and saturating performance counters. Sits beside the hazard/forwarding logic and drives the IF/ID, ID/EX, EX/MEM and MEM/WB register controls plus the PC enable.

Parameters:
TIMEOUT, 16, max consecutive MEM_WAIT cycles before a fatal error (>=2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
id_rn  in  5  Rn field of the instruction in ID
id_rm  in  5  second source register in ID (after Reg2Loc mux)
id_uses_rm  in  1  instruction in ID reads id_rm
ex_memread  in  1  MemRead held in ID/EX
ex_rd  in  5  destination register held in ID/EX
mem_pcsrc  in  1  taken branch resolved in MEM (Branch & Zero / unconditional)
dmem_req  in  1  MEM stage is accessing data memory (MemRead|MemWrite)
dmem_ack  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clears to NOP
idex_flush  out  1  ID/EX loads a bubble (all control bits 0)
exmem_en  out  1  EX/MEM enable
exmem_flush  out  1  EX/MEM loads a bubble
memwb_flush  out  1  MEM/WB loads a bubble
err  out  1  sticky watchdog error
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  branch flush events

Behaviour:
- States: RUN, MEM_WAIT, ERROR (2-bit enum). Reset -> RUN, wait_cnt=0, err=0, both counters 0.
- Outputs are combinational from state and inputs. Defaults: all enables 1, all flushes 0.
- freeze = dmem_req & ~dmem_ack. A single-cycle memory (ack in the same cycle as req) never stalls.
- Priority: ERROR > freeze > branch flush > load-use.
- ERROR: pc_en=ifid_en=exmem_en=0, every flush 0, err=1. The block stays in ERROR until reset_n.
- freeze (RUN or MEM_WAIT): pc_en=ifid_en=exmem_en=0, idex_flush=0 (ID/EX is also held; its enable is tied to exmem_en externally), memwb_flush=1 so no duplicate writeback.
- RUN->MEM_WAIT when freeze. MEM_WAIT->RUN on the cycle dmem_ack=1. Deasserting dmem_req in MEM_WAIT also returns to RUN; this is illegal for a conforming memory and is tolerated anyway.
- wait_cnt: cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack. When it reaches TIMEOUT-1 with no ack: next state ERROR, err set.
- Branch flush (no freeze, mem_pcsrc=1): ifid_flush=idex_flush=exmem_flush=1, pc_en=1. This squashes the three younger instructions. Load-use is ignored in the same cycle.
- Load-use: hit = ex_memread & (ex_rd!=31) & ((ex_rd==id_rn) | (id_uses_rm & ex_rd==id_rm)). On hit: pc_en=0, ifid_en=0, idex_flush=1. This gives exactly one bubble, because next cycle the load has left ID/EX.
- XZR (31) never creates a hazard.
- stall_cnt increments on each cycle with pc_en=0 and state!=ERROR. flush_cnt increments on each branch flush. Both saturate at all-ones.
- reset_n asserted mid-stall forces RUN immediately. Outputs return to defaults in the same cycle.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, MEM_WAIT, ERROR), XZR constant (5'd31), default TIMEOUT value.
- One sub-module, sat_counter (width param, inc, reset_n), instantiated twice for the counters.
- Hazard compare and FSM stay in pipe_ctrl.

Test Plan:
1. ex_memread=1, ex_rd=3, id_rn=3, no mem/branch -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. With id_rn=31, ex_rd=31 -> no stall.
2. Load-use via rm: ex_rd=5, id_rm=5: id_uses_rm=0 -> no stall; id_uses_rm=1 -> stall.
3. mem_pcsrc=1 together with a load-use hit -> ifid/idex/exmem flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
4. dmem_req=1 with ack 3 cycles later -> 3 cycles frozen with memwb_flush=1, state MEM_WAIT, back to RUN on ack; stall_cnt=3. ack in the same cycle as req -> no freeze.
5. TIMEOUT=4, dmem_req held, no ack -> ERROR after 4 frozen cycles, err=1 sticky; enables stay 0 after ack.
6. Drop reset_n during MEM_WAIT -> outputs default immediately, counters 0, err=0. CNT_W=4 with 20 stall cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the LEGv8 pipeline sequencer.
// Included by pipe_ctrl and by anything that needs to decode its state.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [4:0] XZR         = 5'd31;
    localparam int         TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones once full.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables/flushes from load-use, MEM branch and
// variable-latency data memory, with a memory-wait watchdog and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_pcsrc,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic              err_q;

    logic freeze;
    logic hit;
    logic branch;

    assign freeze = dmem_req & ~dmem_ack;
    assign hit    = ex_memread & (ex_rd != XZR) &
                    ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));

    // Reset also forces defaults so a mid-stall reset releases the pipe at once.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        branch      = 1'b0;
        if (!reset_n) begin
            pc_en = 1'b1;
        end else if (state_q == ERROR) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (mem_pcsrc) begin
            branch      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Checking TIMEOUT-2 before increment gives exactly TIMEOUT frozen cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (freeze) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!freeze) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 2)) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                    end
                end
                ERROR:   state_q <= ERROR;
                default: state_q <= RUN;
            endcase
        end
    end

    assign err = err_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .inc_i     (~pc_en & (state_q != ERROR)),
        .cnt_o     (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .inc_i     (branch),
        .cnt_o     (flush_cnt)
    );

endmodule
